// File: rtl/register_file_mp.sv
// register_file_mp: multi-port register file, reg 0 hardwired to zero, with per-register busy scoreboard.
// Define RF_BYPASS_EN to forward a same-edge write to reads of that register.
module register_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       writeEnable,
    input  logic [ADDR_W-1:0]          writeReg,
    input  logic [DATA_W-1:0]          writeData,
    input  logic                       reserveEnable,
    input  logic [ADDR_W-1:0]          reserveReg,
    input  logic [NUM_READ*ADDR_W-1:0] readReg,
    output logic [NUM_READ*DATA_W-1:0] readData,
    output logic [NUM_READ-1:0]        readBusy
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]          rf_view [NUM_REGS];
    logic [NUM_REGS-1:0]        busy_next;
    logic [NUM_READ*DATA_W-1:0] rd_next;
    logic [NUM_READ-1:0]        rb_next;

    assign rf_view[0]   = '0;
    assign busy_next[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        logic [DATA_W-1:0] q;
        logic              b;
        logic              hit_w;
        logic              hit_r;
        assign hit_w        = writeEnable && writeReg == ADDR_W'(r);
        assign hit_r        = reserveEnable && reserveReg == ADDR_W'(r);
        // a reserve wins over a same-edge write: the new producer keeps it busy
        assign busy_next[r] = hit_r | (b & ~hit_w);
        assign rf_view[r]   = q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
                b <= 1'b0;
            end else begin
                if (hit_w) q <= writeData;
                b <= busy_next[r];
            end
        end
    end

    always_comb begin
        rd_next = '0;
        rb_next = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            rd_next[p*DATA_W +: DATA_W] = rf_view[readReg[p*ADDR_W +: ADDR_W]];
            rb_next[p]                  = busy_next[readReg[p*ADDR_W +: ADDR_W]];
`ifdef RF_BYPASS_EN
            if (writeEnable && writeReg != '0 && writeReg == readReg[p*ADDR_W +: ADDR_W])
                rd_next[p*DATA_W +: DATA_W] = writeData;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readData <= '0;
            readBusy <= '0;
        end else begin
            readData <= rd_next;
            readBusy <= rb_next;
        end
    end
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed and random checks of register_file_mp in two configurations against a reference model.
module tb_register_file_mp;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_we, a_re;
    logic [4:0]  a_wr, a_rr;
    logic [31:0] a_wd;
    logic [9:0]  a_rreg;
    logic [63:0] a_rdata;
    logic [1:0]  a_rbusy;

    logic        b_we, b_re;
    logic [2:0]  b_wr, b_rr;
    logic [15:0] b_wd;
    logic [8:0]  b_rreg;
    logic [47:0] b_rdata;
    logic [2:0]  b_rbusy;

    int n_tests = 0;
    int n_fail  = 0;

    register_file_mp dut_a (
        .clk(clk), .rst_n(rst_n),
        .writeEnable(a_we), .writeReg(a_wr), .writeData(a_wd),
        .reserveEnable(a_re), .reserveReg(a_rr),
        .readReg(a_rreg), .readData(a_rdata), .readBusy(a_rbusy)
    );

    register_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_READ(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .writeEnable(b_we), .writeReg(b_wr), .writeData(b_wd),
        .reserveEnable(b_re), .reserveReg(b_rr),
        .readReg(b_rreg), .readData(b_rdata), .readBusy(b_rbusy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: storage arrays plus the expected registered outputs
    logic [31:0] ma [32];
    logic        ba [32];
    logic [31:0] ea_d [2];
    logic        ea_b [2];
    int          ra;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin ma[i] = '0; ba[i] = 1'b0; end
            for (int p = 0; p < 2; p++) begin ea_d[p] = '0; ea_b[p] = 1'b0; end
        end else begin
            if (a_we && a_wr != 0) ba[a_wr] = 1'b0;
            if (a_re && a_rr != 0) ba[a_rr] = 1'b1;
            for (int p = 0; p < 2; p++) begin
                ra      = int'(a_rreg[p*5 +: 5]);
                ea_b[p] = ba[ra];
                ea_d[p] = ra == 0 ? 32'h0 : (BYP && a_we && int'(a_wr) == ra) ? a_wd : ma[ra];
            end
            if (a_we && a_wr != 0) ma[a_wr] = a_wd;
        end
    end

    logic [15:0] mb [8];
    logic        bb [8];
    logic [15:0] eb_d [3];
    logic        eb_b [3];
    int          rb;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin mb[i] = '0; bb[i] = 1'b0; end
            for (int p = 0; p < 3; p++) begin eb_d[p] = '0; eb_b[p] = 1'b0; end
        end else begin
            if (b_we && b_wr != 0) bb[b_wr] = 1'b0;
            if (b_re && b_rr != 0) bb[b_rr] = 1'b1;
            for (int p = 0; p < 3; p++) begin
                rb      = int'(b_rreg[p*3 +: 3]);
                eb_b[p] = bb[rb];
                eb_d[p] = rb == 0 ? 16'h0 : (BYP && b_we && int'(b_wr) == rb) ? b_wd : mb[rb];
            end
            if (b_we && b_wr != 0) mb[b_wr] = b_wd;
        end
    end

    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("a_data[%0d]", p), a_rdata[p*32 +: 32], ea_d[p]);
            chk($sformatf("a_busy[%0d]", p), 32'(a_rbusy[p]), 32'(ea_b[p]));
        end
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("b_data[%0d]", p), 32'(b_rdata[p*16 +: 16]), 32'(eb_d[p]));
            chk($sformatf("b_busy[%0d]", p), 32'(b_rbusy[p]), 32'(eb_b[p]));
        end
    end

    task automatic idle_a();
        a_we = 1'b0;
        a_re = 1'b0;
    endtask

    task automatic wr_a(input logic [4:0] r, input logic [31:0] d);
        a_we = 1'b1;
        a_wr = r;
        a_wd = d;
    endtask

    task automatic rd_a(input logic [4:0] p0, input logic [4:0] p1);
        a_rreg = {p1, p0};
    endtask

    initial begin
        rst_n = 1'b0;
        a_we = 0; a_re = 0; a_wr = 0; a_rr = 0; a_wd = 0; a_rreg = 0;
        b_we = 0; b_re = 0; b_wr = 0; b_rr = 0; b_wd = 0; b_rreg = 0;
        repeat (2) @(negedge clk);
        chk("reset_data", a_rdata[31:0], 32'h0);
        chk("reset_busy", 32'(a_rbusy), 32'h0);
        rst_n = 1'b1;

        // reg 5 written and reserved, then an asynchronous mid-cycle reset
        wr_a(5, 32'hDEADBEEF); a_re = 1'b1; a_rr = 5; rd_a(5, 0);
        @(negedge clk);
        idle_a();
        @(negedge clk);
        chk("r5_data", a_rdata[31:0], 32'hDEADBEEF);
        chk("r5_busy", 32'(a_rbusy[0]), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_data", a_rdata[31:0], 32'h0);
        chk("async_rst_busy", 32'(a_rbusy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("r5_after_rst", a_rdata[31:0], 32'h0);

        // basic write then read on both ports
        wr_a(7, 32'h12345678); rd_a(0, 0);
        @(negedge clk);
        idle_a(); rd_a(7, 7);
        @(negedge clk);
        chk("r7_p0", a_rdata[31:0], 32'h12345678);
        chk("r7_p1", a_rdata[63:32], 32'h12345678);

        // reg 0 ignores writes and reserves
        wr_a(0, 32'hFFFFFFFF); a_re = 1'b1; a_rr = 0; rd_a(0, 0);
        @(negedge clk);
        chk("r0_busy_same", 32'(a_rbusy), 32'h0);
        idle_a();
        @(negedge clk);
        chk("r0_data", a_rdata, 64'h0);
        chk("r0_busy", 32'(a_rbusy), 32'h0);

        // same-edge write and read of reg 3
        wr_a(3, 32'hAAAA0000);
        @(negedge clk);
        wr_a(3, 32'h5555FFFF); rd_a(3, 3);
        @(negedge clk);
        chk("bypass_p0", a_rdata[31:0], BYP ? 32'h5555FFFF : 32'hAAAA0000);
        chk("bypass_p1", a_rdata[63:32], BYP ? 32'h5555FFFF : 32'hAAAA0000);
        idle_a();
        @(negedge clk);
        chk("r3_next", a_rdata[31:0], 32'h5555FFFF);

        // scoreboard on reg 10
        a_re = 1'b1; a_rr = 10; rd_a(10, 7);
        @(negedge clk);
        chk("sb_set", 32'(a_rbusy), 32'h1);
        idle_a();
        repeat (2) @(negedge clk);
        chk("sb_hold", 32'(a_rbusy[0]), 32'h1);
        wr_a(10, 32'hCAFEF00D);
        @(negedge clk);
        chk("sb_clear", 32'(a_rbusy[0]), 32'h0);
        chk("sb_wdata", a_rdata[31:0], BYP ? 32'hCAFEF00D : 32'h0);
        wr_a(10, 32'h0BADC0DE); a_re = 1'b1; a_rr = 10;
        @(negedge clk);
        chk("sb_res_wr", 32'(a_rbusy[0]), 32'h1);
        idle_a();
        @(negedge clk);
        chk("sb_res_wr_hold", 32'(a_rbusy[0]), 32'h1);
        chk("sb_res_wr_data", a_rdata[31:0], 32'h0BADC0DE);

        // narrow configuration: fill regs 1..7 and read them in rotation
        for (int r = 1; r < 8; r++) begin
            b_we = 1'b1; b_wr = 3'(r); b_wd = 16'(r * 16'h0101);
            @(negedge clk);
        end
        b_we = 1'b0;
        for (int k = 0; k < 7; k++) begin
            for (int p = 0; p < 3; p++) b_rreg[p*3 +: 3] = 3'((k + p) % 7 + 1);
            @(negedge clk);
            for (int p = 0; p < 3; p++)
                chk("sweep", 32'(b_rdata[p*16 +: 16]), 32'(((k + p) % 7 + 1) * 16'h0101));
        end

        // random traffic on both instances, checked against the model every cycle
        for (int i = 0; i < 80; i++) begin
            a_we = 1'($urandom); a_wr = 5'($urandom_range(0, 7)); a_wd = $urandom;
            a_re = 1'($urandom_range(0, 3) == 0); a_rr = 5'($urandom_range(0, 7));
            rd_a(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            b_we = 1'($urandom); b_wr = 3'($urandom); b_wd = 16'($urandom);
            b_re = 1'($urandom_range(0, 3) == 0); b_rr = 3'($urandom);
            b_rreg = 9'($urandom);
            @(negedge clk);
        end
        idle_a();
        b_we = 1'b0; b_re = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Parametrised successor to the RISC-V core register file. It provides DATA_W-wide registers, 2**ADDR_W entries, NUM_READ registered read ports and one write port. Register 0 is hardwired to zero. A per-register busy scoreboard lets the pipeline mark registers awaiting a pending write-back, and an optional write-to-read bypass is available. It sits between decode (read and reserve) and write-back (write) in the core datapath.

Parameters:
DATA_W, 32, width of each register and data bus.
ADDR_W, 5, register address width; number of registers NUM_REGS = 2**ADDR_W (including hardwired reg 0).
NUM_READ, 2, number of independent read ports (1..4).

Ports:
clk  input  1  main processor clock; all state changes on posedge.
rst_n  input  1  asynchronous active-low reset.
writeEnable  input  1  write strobe for writeReg/writeData.
writeReg  input  ADDR_W  destination register of write.
writeData  input  DATA_W  data to write.
reserveEnable  input  1  marks reserveReg busy (pending producer issued).
reserveReg  input  ADDR_W  register to mark busy.
readReg  input  NUM_READ*ADDR_W  packed read addresses; port p at bits [p*ADDR_W +: ADDR_W].
readData  output  NUM_READ*DATA_W  packed registered read data; port p at [p*DATA_W +: DATA_W].
readBusy  output  NUM_READ  registered busy flag of the register addressed by each port.

Behaviour:
- Reset: the design has one clock. Reset is asynchronous and active-low. While rst_n=0, and immediately on its assertion even mid-cycle, the following all go to 0: every register, every busy bit, readData and readBusy. The first write is accepted on the first posedge with rst_n=1.
- Storage: NUM_REGS-1 physical registers, indices 1..NUM_REGS-1; no storage for index 0.
- Write: on posedge, if writeEnable=1 and writeReg!=0, then reg[writeReg] <= writeData. Writes to reg 0 are silently discarded.
- Busy scoreboard, evaluated on each posedge:
  - busy_next[r] = reserve sets it, else write clears it, else it holds.
  - Set: reserveEnable and reserveReg==r and r!=0.
  - Clear: writeEnable and writeReg==r.
  - Reserve and write to the same register in the same cycle: the register stays busy (new producer), and the data is still written.
  - busy[0] is always 0; a reserve of reg 0 is ignored.
- Read, 1-cycle latency:
  - On each posedge, each port p registers readData[p] from readReg[p] sampled at that edge.
  - readReg[p]==0 gives 0.
  - Otherwise readData[p] gets the register contents, subject to the bypass rule below.
  - readBusy[p] <= busy_next[readReg[p]]; it reflects the scoreboard after the same-edge update, independent of the macro.
  - Reads are performed every cycle; there is no read enable.
- Multiple ports may address the same register; every port returns identical data.
- Width rules: no truncation or extension; packed buses are exact multiples.
- Out-of-range addresses are impossible, because the register count is exactly 2**ADDR_W.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: on a same-edge write-and-read of the same nonzero register, readData returns the new writeData (write-through).
- Undefined: it returns the old stored value. The new value is visible from the following read edge.
- Reg 0 reads return 0 in both cases.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle after writing reg 5=0xDEADBEEF. Required: readData and readBusy go 0 immediately. After release, a read of reg 5 returns 0x00000000.
- Basic write/read: write reg 7=0x12345678 at edge N, then read port0=7 and port1=7 at edge N+1. Required: both readData = 0x12345678 after edge N+1.
- Reg 0: write reg 0=0xFFFFFFFF, then read reg 0 on all ports. Required: readData=0 and readBusy=0. A reserve of reg 0 leaves readBusy=0.
- Same-cycle bypass: reg 3 holds 0xAAAA0000. At one edge, write reg 3=0x5555FFFF and read reg 3. Required: readData=0x5555FFFF with RF_BYPASS_EN, or 0xAAAA0000 without it. The next read returns 0x5555FFFF either way.
- Scoreboard:
  - Reserve reg 10 at edge N while reading reg 10. Required: readBusy=1 after edge N.
  - Write reg 10 at edge N+3 while reading. Required: readBusy=0 and readData equals the written data (bypass on).
  - Reserve and write reg 10 at the same edge. Required: busy stays 1.
- Parameter sweep: DATA_W=16, ADDR_W=3, NUM_READ=3; write each of regs 1..7 with value r*0x0101, then read all in a rotation across the ports. Required: every port returns the correct value with 1-cycle latency.
